// File: rtl/ipif_rr_arbiter_pkg.sv
// Shared types and helpers for the IPIF round-robin arbiter.
// The optional bus-hang timeout is enabled by defining IPIF_ARB_TIMEOUT_EN.
package ipif_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        TURN = 2'd2
    } arb_state_t;

    // Read data returned to a master whose transaction was abandoned by the timeout
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ipif_rr_arbiter_if.sv
// Bundle of master-side (packed per master) and slave-side IPIF signals.
// The arbiter uses the slave modport; the masters/register file sit on the master modport.
interface ipif_rr_arbiter_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int NUM_MASTERS        = 2
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int N  = NUM_MASTERS;

    logic [N-1:0]        M_CS;
    logic [N-1:0]        M_RNW;
    logic [N*AW-1:0]     M_Addr;
    logic [N*DW-1:0]     M_Data;
    logic [N*DW/8-1:0]   M_BE;
    logic [DW-1:0]       M_RdData;
    logic [N-1:0]        M_RdAck;
    logic [N-1:0]        M_WrAck;
    logic [N-1:0]        M_Error;

    logic                S_CS;
    logic                S_RNW;
    logic [AW-1:0]       S_Addr;
    logic [DW-1:0]       S_Data;
    logic [DW/8-1:0]     S_BE;
    logic [DW-1:0]       S_RdData;
    logic                S_RdAck;
    logic                S_WrAck;
    logic                S_Error;

    modport slave (
        input  M_CS, M_RNW, M_Addr, M_Data, M_BE, S_RdData, S_RdAck, S_WrAck, S_Error,
        output M_RdData, M_RdAck, M_WrAck, M_Error, S_CS, S_RNW, S_Addr, S_Data, S_BE
    );

    modport master (
        output M_CS, M_RNW, M_Addr, M_Data, M_BE, S_RdData, S_RdAck, S_WrAck, S_Error,
        input  M_RdData, M_RdAck, M_WrAck, M_Error, S_CS, S_RNW, S_Addr, S_Data, S_BE
    );

endinterface

// File: rtl/ipif_rr_arbiter_sel.sv
// Combinational rotating priority encoder: picks the first requester after i_last_ptr,
// wrapping from NUM_MASTERS-1 back to 0.
module rr_priority_sel
    import ipif_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int IW          = idx_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [IW-1:0]          i_last_ptr,
    output logic                   o_valid,
    output logic [IW-1:0]          o_idx,
    output logic [NUM_MASTERS-1:0] o_onehot
);

    logic [IW-1:0]          w_cand [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] w_hit;

    // Slot gi holds the master that is gi+1 positions after the last grant
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_cand
        assign w_cand[gi] = IW'((32'(i_last_ptr) + 32'(gi) + 32'd1) % 32'(NUM_MASTERS));
        assign w_hit[gi]  = i_req[w_cand[gi]];
    end

    always_comb begin
        o_valid  = |w_hit;
        o_idx    = '0;
        o_onehot = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                o_idx = w_cand[k];
            end
        end
        if (o_valid) begin
            o_onehot[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/ipif_rr_arbiter.sv
// Round-robin arbiter sharing one IPIF register slave between NUM_MASTERS masters.
// Define IPIF_ARB_TIMEOUT_EN to force an error ack after TIMEOUT_CYCLES silent WAIT cycles.
module ipif_rr_arbiter
    import ipif_arb_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int NUM_MASTERS        = 2,
    parameter int TIMEOUT_CYCLES     = 255
) (
    input  logic                   Bus2IP_Clk,
    input  logic                   Bus2IP_Reset,
    ipif_rr_arbiter_if.slave       bus,
    output logic [NUM_MASTERS-1:0] grant
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int N  = NUM_MASTERS;
    localparam int BW = DW / 8;
    localparam int IW = idx_width(N);

    if (N < 2 || N > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
        $error("ipif_rr_arbiter: parameter out of range");
    end

    arb_state_t    r_state, w_state_next;
    logic [IW-1:0] r_ptr, w_ptr_next;
    logic          r_s_cs, w_s_cs_next;
    logic          r_s_rnw, w_s_rnw_next;
    logic [AW-1:0] r_s_addr, w_s_addr_next;
    logic [DW-1:0] r_s_data, w_s_data_next;
    logic [BW-1:0] r_s_be, w_s_be_next;
    logic [DW-1:0] r_m_rddata, w_m_rddata_next;
    logic [N-1:0]  r_m_rdack, w_m_rdack_next;
    logic [N-1:0]  r_m_wrack, w_m_wrack_next;
    logic [N-1:0]  r_m_error, w_m_error_next;
    logic [N-1:0]  r_grant, w_grant_next;
`ifdef IPIF_ARB_TIMEOUT_EN
    logic [15:0]   r_cnt, w_cnt_next;
`endif

    logic          w_sel_valid;
    logic [IW-1:0] w_sel_idx;
    logic [N-1:0]  w_sel_onehot;
    logic          w_resp;
    logic          w_resp_err;
    logic [DW-1:0] w_resp_data;

    rr_priority_sel #(.NUM_MASTERS(N), .IW(IW)) u_sel (
        .i_req      (bus.M_CS),
        .i_last_ptr (r_ptr),
        .o_valid    (w_sel_valid),
        .o_idx      (w_sel_idx),
        .o_onehot   (w_sel_onehot)
    );

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            r_state    <= IDLE;
            r_ptr      <= IW'(N - 1);
            r_s_cs     <= 1'b0;
            r_s_rnw    <= 1'b0;
            r_s_addr   <= '0;
            r_s_data   <= '0;
            r_s_be     <= '0;
            r_m_rddata <= '0;
            r_m_rdack  <= '0;
            r_m_wrack  <= '0;
            r_m_error  <= '0;
            r_grant    <= '0;
`ifdef IPIF_ARB_TIMEOUT_EN
            r_cnt      <= '0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_ptr      <= w_ptr_next;
            r_s_cs     <= w_s_cs_next;
            r_s_rnw    <= w_s_rnw_next;
            r_s_addr   <= w_s_addr_next;
            r_s_data   <= w_s_data_next;
            r_s_be     <= w_s_be_next;
            r_m_rddata <= w_m_rddata_next;
            r_m_rdack  <= w_m_rdack_next;
            r_m_wrack  <= w_m_wrack_next;
            r_m_error  <= w_m_error_next;
            r_grant    <= w_grant_next;
`ifdef IPIF_ARB_TIMEOUT_EN
            r_cnt      <= w_cnt_next;
`endif
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_ptr_next      = r_ptr;
        w_s_cs_next     = r_s_cs;
        w_s_rnw_next    = r_s_rnw;
        w_s_addr_next   = r_s_addr;
        w_s_data_next   = r_s_data;
        w_s_be_next     = r_s_be;
        w_m_rddata_next = r_m_rddata;
        w_m_rdack_next  = '0;
        w_m_wrack_next  = '0;
        w_m_error_next  = '0;
        w_grant_next    = r_grant;
        w_resp          = 1'b0;
        w_resp_err      = 1'b0;
        w_resp_data     = bus.S_RdData;
`ifdef IPIF_ARB_TIMEOUT_EN
        w_cnt_next      = r_cnt;
`endif
        case (r_state)
            IDLE: begin
                if (w_sel_valid) begin
                    w_s_cs_next   = 1'b1;
                    w_s_rnw_next  = bus.M_RNW[w_sel_idx];
                    w_s_addr_next = bus.M_Addr[32'(w_sel_idx) * AW +: AW];
                    w_s_data_next = bus.M_Data[32'(w_sel_idx) * DW +: DW];
                    w_s_be_next   = bus.M_BE[32'(w_sel_idx) * BW +: BW];
                    w_grant_next  = w_sel_onehot;
                    w_ptr_next    = w_sel_idx;
                    w_state_next  = WAIT;
`ifdef IPIF_ARB_TIMEOUT_EN
                    w_cnt_next    = '0;
`endif
                end
            end
            WAIT: begin
                if (bus.S_RdAck | bus.S_WrAck) begin
                    w_resp     = 1'b1;
                    w_resp_err = bus.S_Error;
                end
`ifdef IPIF_ARB_TIMEOUT_EN
                else if (r_cnt == 16'(TIMEOUT_CYCLES)) begin
                    w_resp      = 1'b1;
                    w_resp_err  = 1'b1;
                    w_resp_data = DW'(TIMEOUT_DATA);
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
`endif
                // Ack kind follows the latched RNW, not whichever slave ack fired
                if (w_resp) begin
                    w_s_cs_next  = 1'b0;
                    w_grant_next = '0;
                    w_state_next = TURN;
                    if (r_s_rnw) begin
                        w_m_rdack_next[r_ptr] = 1'b1;
                        w_m_rddata_next       = w_resp_data;
                    end else begin
                        w_m_wrack_next[r_ptr] = 1'b1;
                    end
                    w_m_error_next[r_ptr] = w_resp_err;
                end
            end
            TURN:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign bus.S_CS     = r_s_cs;
    assign bus.S_RNW    = r_s_rnw;
    assign bus.S_Addr   = r_s_addr;
    assign bus.S_Data   = r_s_data;
    assign bus.S_BE     = r_s_be;
    assign bus.M_RdData = r_m_rddata;
    assign bus.M_RdAck  = r_m_rdack;
    assign bus.M_WrAck  = r_m_wrack;
    assign bus.M_Error  = r_m_error;
    assign grant        = r_grant;

endmodule

// File: tb/tb_ipif_rr_arbiter.sv
// Directed self-checking bench for ipif_rr_arbiter (two masters, TIMEOUT_CYCLES=4).
// Outputs are sampled 1 ns after the rising edge; inputs are driven in the same slot.
module tb_ipif_rr_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int N  = 2;
    localparam int TO = 4;

    logic         clk  = 1'b0;
    logic         srst = 1'b1;
    logic [N-1:0] grant;
    int           n_checks = 0;
    int           n_fail   = 0;

    always #5 clk = ~clk;

    ipif_rr_arbiter_if #(
        .C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW), .NUM_MASTERS(N)
    ) bus ();

    ipif_rr_arbiter #(
        .C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW),
        .NUM_MASTERS(N), .TIMEOUT_CYCLES(TO)
    ) dut (
        .Bus2IP_Clk   (clk),
        .Bus2IP_Reset (srst),
        .bus          (bus),
        .grant        (grant)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_master(input int m, input logic rnw, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] be);
        bus.M_RNW[m]           = rnw;
        bus.M_Addr[m*AW +: AW] = addr;
        bus.M_Data[m*DW +: DW] = data;
        bus.M_BE[m*4 +: 4]     = be;
    endtask

    task automatic wait_scs(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (bus.S_CS) break;
            tick();
        end
        chk(tag, 64'(bus.S_CS), 64'h1);
    endtask

    task automatic do_reset();
        srst        = 1'b1;
        bus.M_CS    = '0;
        bus.S_RdAck = 1'b0;
        bus.S_WrAck = 1'b0;
        bus.S_Error = 1'b0;
        tick();
        tick();
        chk("rst_scs",    64'(bus.S_CS), 64'h0);
        chk("rst_grant",  64'(grant), 64'h0);
        chk("rst_acks",   64'({bus.M_RdAck, bus.M_WrAck, bus.M_Error}), 64'h0);
        chk("rst_rddata", 64'(bus.M_RdData), 64'h0);
        chk("rst_saddr",  64'(bus.S_Addr), 64'h0);
        srst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  exp_g [4];
        logic [31:0] exp_a [4];
        int          cnt;

        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_a = '{32'h10, 32'h20, 32'h10, 32'h20};

        bus.M_CS     = '0;
        bus.M_RNW    = '0;
        bus.M_Addr   = '0;
        bus.M_Data   = '0;
        bus.M_BE     = '0;
        bus.S_RdData = '0;
        bus.S_RdAck  = 1'b0;
        bus.S_WrAck  = 1'b0;
        bus.S_Error  = 1'b0;

        // T1: single read from master 0, slave acks one cycle after S_CS rises
        do_reset();
        set_master(0, 1'b1, 32'h8, 32'h0, 4'hF);
        bus.M_CS = 2'b01;
        tick();
        chk("t1_scs_rise", 64'(bus.S_CS), 64'h1);
        chk("t1_saddr",    64'(bus.S_Addr), 64'h8);
        chk("t1_srnw",     64'(bus.S_RNW), 64'h1);
        chk("t1_grant",    64'(grant), 64'h1);
        tick();
        chk("t1_scs_hold", 64'(bus.S_CS), 64'h1);
        chk("t1_noack",    64'({bus.M_RdAck, bus.M_WrAck}), 64'h0);
        bus.S_RdAck  = 1'b1;
        bus.S_RdData = 32'h1234;
        tick();
        bus.S_RdAck = 1'b0;
        bus.M_CS    = 2'b00;
        chk("t1_rdack",    64'(bus.M_RdAck), 64'h1);
        chk("t1_wrack",    64'(bus.M_WrAck), 64'h0);
        chk("t1_rddata",   64'(bus.M_RdData), 64'h1234);
        chk("t1_error",    64'(bus.M_Error), 64'h0);
        chk("t1_scs_fall", 64'(bus.S_CS), 64'h0);
        chk("t1_grant_clr", 64'(grant), 64'h0);
        tick();
        chk("t1_pulse_end", 64'(bus.M_RdAck), 64'h0);
        $display("txn T1 read m0 addr=8 data=%0h", bus.M_RdData);

        // T2: both masters request continuously; strict alternation from master 0
        do_reset();
        set_master(0, 1'b1, 32'h10, 32'h0, 4'hF);
        set_master(1, 1'b1, 32'h20, 32'h0, 4'hF);
        bus.M_CS = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_scs("t2_scs");
            chk("t2_grant", 64'(grant), 64'(exp_g[k]));
            chk("t2_saddr", 64'(bus.S_Addr), 64'(exp_a[k]));
            bus.S_RdAck  = 1'b1;
            bus.S_RdData = 32'hA000 + 32'(k);
            tick();
            bus.S_RdAck = 1'b0;
            chk("t2_route",  64'(bus.M_RdAck), 64'(exp_g[k]));
            chk("t2_rddata", 64'(bus.M_RdData), 64'hA000 + 64'(k));
            $display("txn T2 #%0d grant=%b rdack=%b data=%0h", k, exp_g[k], bus.M_RdAck, bus.M_RdData);
        end
        bus.M_CS = 2'b00;
        tick();
        tick();

        // T3: slave acks in WAIT and again in TURN; only one write ack reaches the master
        set_master(1, 1'b0, 32'h30, 32'hCAFE_0001, 4'b0011);
        bus.M_CS = 2'b10;
        wait_scs("t3_scs");
        chk("t3_grant", 64'(grant), 64'h2);
        chk("t3_srnw",  64'(bus.S_RNW), 64'h0);
        chk("t3_sdata", 64'(bus.S_Data), 64'hCAFE_0001);
        chk("t3_sbe",   64'(bus.S_BE), 64'h3);
        bus.S_WrAck = 1'b1;
        cnt = 0;
        tick();
        chk("t3_route", 64'(bus.M_WrAck), 64'h2);
        cnt += $countones(bus.M_WrAck) + $countones(bus.M_RdAck);
        bus.M_CS = 2'b00;
        tick();
        cnt += $countones(bus.M_WrAck) + $countones(bus.M_RdAck);
        bus.S_WrAck = 1'b0;
        repeat (3) begin
            tick();
            cnt += $countones(bus.M_WrAck) + $countones(bus.M_RdAck);
        end
        chk("t3_pulses", 64'(cnt), 64'h1);
        $display("txn T3 write m1 dup-ack pulses=%0d", cnt);

        // T4: write that the slave answers with an error
        set_master(1, 1'b0, 32'h34, 32'h5555, 4'hF);
        bus.M_CS = 2'b10;
        wait_scs("t4_scs");
        bus.S_WrAck = 1'b1;
        bus.S_Error = 1'b1;
        tick();
        bus.S_WrAck = 1'b0;
        bus.S_Error = 1'b0;
        bus.M_CS    = 2'b00;
        chk("t4_wrack",  64'(bus.M_WrAck), 64'h2);
        chk("t4_error",  64'(bus.M_Error), 64'h2);
        chk("t4_rdack",  64'(bus.M_RdAck), 64'h0);
        chk("t4_rddata", 64'(bus.M_RdData), 64'hA003);
        $display("txn T4 write m1 err wrack=%b error=%b", bus.M_WrAck, bus.M_Error);
        tick();

        // T5: reset one cycle into WAIT, together with a slave ack; reset wins
        set_master(0, 1'b1, 32'h40, 32'h0, 4'hF);
        bus.M_CS = 2'b01;
        wait_scs("t5_scs");
        chk("t5_grant", 64'(grant), 64'h1);
        tick();
        srst         = 1'b1;
        bus.S_RdAck  = 1'b1;
        bus.S_RdData = 32'hBAD0;
        tick();
        chk("t5_scs_off",  64'(bus.S_CS), 64'h0);
        chk("t5_grant_off", 64'(grant), 64'h0);
        chk("t5_rddata",   64'(bus.M_RdData), 64'h0);
        srst        = 1'b0;
        bus.S_RdAck = 1'b0;
        bus.M_CS    = 2'b00;
        cnt = $countones(bus.M_RdAck) + $countones(bus.M_WrAck);
        repeat (5) begin
            tick();
            cnt += $countones(bus.M_RdAck) + $countones(bus.M_WrAck);
        end
        chk("t5_no_ack", 64'(cnt), 64'h0);
        set_master(1, 1'b1, 32'h44, 32'h0, 4'hF);
        bus.M_CS = 2'b11;
        wait_scs("t5_scs2");
        chk("t5_first_m0", 64'(grant), 64'h1);
        chk("t5_saddr",    64'(bus.S_Addr), 64'h40);
        bus.S_RdAck  = 1'b1;
        bus.S_RdData = 32'h5A5A;
        tick();
        bus.S_RdAck = 1'b0;
        bus.M_CS    = 2'b00;
        chk("t5_rdack",  64'(bus.M_RdAck), 64'h1);
        chk("t5_rddata", 64'(bus.M_RdData), 64'h5A5A);
        $display("txn T5 reset-in-wait, next grant m0 data=%0h", bus.M_RdData);
        tick();
        tick();

        // T6: silent slave on a read
        set_master(0, 1'b1, 32'h50, 32'h0, 4'hF);
        bus.M_CS = 2'b01;
        wait_scs("t6_scs");
`ifdef IPIF_ARB_TIMEOUT_EN
        cnt = 0;
        repeat (4) begin
            tick();
            cnt += $countones(bus.M_RdAck);
        end
        chk("t6_early_ack", 64'(cnt), 64'h0);
        tick();
        bus.M_CS = 2'b00;
        chk("t6_to_rdack",  64'(bus.M_RdAck), 64'h1);
        chk("t6_to_error",  64'(bus.M_Error), 64'h1);
        chk("t6_to_rddata", 64'(bus.M_RdData), 64'hDEAD_BEEF);
        chk("t6_to_scs",    64'(bus.S_CS), 64'h0);
        $display("txn T6 timeout read m0 data=%0h", bus.M_RdData);
        tick();
`else
        cnt = 0;
        repeat (1000) begin
            tick();
            if (!bus.S_CS || (bus.M_RdAck != '0) || (bus.M_WrAck != '0)) cnt++;
        end
        chk("t6_hold",       64'(cnt), 64'h0);
        chk("t6_hold_grant", 64'(grant), 64'h1);
        $display("txn T6 silent read m0 held %0d cycles", 1000);
        do_reset();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
